// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
package arm_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sram_mem_responder_if.sv
// Core-side MEM-stage bus: request, store data, load result and back-pressure.
interface sram_mem_responder_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic        err;

  modport master (
    output rd_en, wr_en, address, wr_data,
    input  rd_data, ready, err
  );

  modport slave (
    input  rd_en, wr_en, address, wr_data,
    output rd_data, ready, err
  );

endinterface

// File: rtl/sram_mem_responder_wait_counter.sv
// Per-phase wait timer: loads WAIT_CYCLES-1, counts down to zero and flags the last clock.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last,
  output logic last_next
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign last      = (cnt_q == '0);
  assign last_next = (cnt_d == '0);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder splitting 32-bit accesses into two half-word async SRAM phases.
// Optional last-read bypass buffer: define SRAM_LAST_READ_BYPASS_EN.
//   state | meaning
//   IDLE  | waiting for rd_en/wr_en
//   LOW   | half-word 0 (bits 15:0) on the pad
//   HIGH  | half-word 1 (bits 31:16) on the pad
//   DONE  | access complete, ready=1
//   ERR   | out-of-range access, ready=1 err=1
module sram_mem_responder
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_responder_if.slave   bus,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_we_n
);

  localparam int          WORD_W     = ADDR_W - 1;
  localparam logic [31:0] SPAN_BYTES = 32'd1 << (ADDR_W + 1);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [15:0]         wdata_hi_q, wdata_hi_d;
  logic [15:0]         lo_q, lo_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                we_n_q, we_n_d;

  logic                req;
  logic                in_range;
  logic                hit;
  logic [31:0]         off;
  logic [WORD_W-1:0]   req_word;
  logic [31:0]         byp_data;
  logic                cnt_load;
  logic                cnt_last;
  logic                cnt_last_next;

  assign req      = bus.rd_en | bus.wr_en;
  assign off      = bus.address - BASE_ADDR;
  assign req_word = off[ADDR_W:2];
  assign in_range = (bus.address >= BASE_ADDR) && (off < SPAN_BYTES);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .last      (cnt_last),
    .last_next (cnt_last_next)
  );

`ifdef SRAM_LAST_READ_BYPASS_EN
  logic              buf_valid_q, buf_valid_d;
  logic [WORD_W-1:0] buf_word_q, buf_word_d;
  logic [31:0]       buf_data_q, buf_data_d;

  assign hit = (state_q == IDLE) && bus.rd_en && !bus.wr_en && in_range &&
               buf_valid_q && (buf_word_q == req_word);
  assign byp_data = buf_data_q;

  // Buffer is refreshed/invalidated in DONE, when rd_data_q already holds the new word.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (state_q == DONE) begin
      if (!is_wr_q) begin
        buf_valid_d = 1'b1;
        buf_word_d  = word_q;
        buf_data_d  = rd_data_q;
      end else if (buf_word_q == word_q) begin
        buf_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign bus.rd_data = hit ? buf_data_q : rd_data_q;
`else
  assign hit         = 1'b0;
  assign byp_data    = '0;
  assign bus.rd_data = rd_data_q;
`endif

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wdata_hi_d  = wdata_hi_q;
    lo_d        = lo_q;
    rd_data_d   = rd_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    cnt_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          rd_data_d = byp_data;
        end else if (req) begin
          is_wr_d    = bus.wr_en;
          word_d     = req_word;
          wdata_hi_d = bus.wr_data[31:16];
          if (!in_range) begin
            state_d = ERR;
            if (!bus.wr_en) rd_data_d = '0;
          end else begin
            state_d     = LOW;
            cnt_load    = 1'b1;
            sram_addr_d = {req_word, LO_HALF};
            if (bus.wr_en) dq_out_d = bus.wr_data[15:0];
          end
        end
      end
      LOW: begin
        if (cnt_last) begin
          state_d     = HIGH;
          cnt_load    = 1'b1;
          lo_d        = sram_dq_in;
          sram_addr_d = {word_q, HI_HALF};
          if (is_wr_q) dq_out_d = wdata_hi_q;
        end
      end
      HIGH: begin
        if (cnt_last) begin
          state_d = DONE;
          if (!is_wr_q) rd_data_d = {sram_dq_in, lo_q};
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobe is released on the final clock of each phase so address/data hold past we_n rising.
    if (is_wr_d && ((state_d == LOW) || (state_d == HIGH))) begin
      dq_oe_d = 1'b1;
      we_n_d  = (WAIT_CYCLES == 1) ? 1'b0 : cnt_last_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      lo_q        <= '0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_hi_q  <= wdata_hi_d;
      lo_q        <= lo_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign bus.ready   = ((state_q == IDLE) && (!req || hit)) ||
                       (state_q == DONE) || (state_q == ERR);
  assign bus.err     = (state_q == ERR);
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: word-level memory model, async SRAM pad model, per-cycle compare.
module tb_sram_mem_responder;

  localparam int          W    = 2;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_mem_responder_if bus();

  sram_mem_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM pad: combinational read, write while we_n is low.
  logic [15:0] sram_arr [0:(1<<AW)-1] = '{default: 16'h0};
  bit pad_init = 1'b0;
  always @(posedge clk) begin
    if (!pad_init) begin
      sram_arr[2] <= 16'h1234;
      sram_arr[3] <= 16'hABCD;
      pad_init    <= 1'b1;
    end else if (!sram_we_n && sram_dq_oe) begin
      sram_arr[sram_addr] <= sram_dq_out;
    end
  end
  assign sram_dq_in = sram_arr[sram_addr];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Spec-level model state
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;
  bit          byp_valid = 1'b0;
  int          byp_word = 0;

  // Current access expectations, written by the driver before req_id steps
  int          exp_lat;
  bit          exp_err;
  bit          exp_wr;
  int          exp_word;
  logic [31:0] exp_data;
  logic [31:0] exp_rd;
  logic [AW-1:0] addr_before;

  int  req_id = 0;
  int  done_id = 0;
  int  cur_id = 0;
  int  cyc = 0;
  int  we_low_cnt = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_id != done_id) begin
        int  ph;
        int  pos;
        logic exp_ready;
        if (cur_id != req_id) begin
          cur_id     = req_id;
          cyc        = 0;
          we_low_cnt = 0;
        end
        if (!sram_we_n) we_low_cnt++;
        exp_ready = (cyc == exp_lat);
        chk1("ready", bus.ready, exp_ready);
        if (exp_ready) begin
          chk1("err", bus.err, exp_err);
          chk("rd_data", bus.rd_data, exp_rd);
        end else begin
          chk1("err_busy", bus.err, 1'b0);
        end
        if (!exp_err && exp_lat != 0 && cyc >= 1 && cyc <= 2*W) begin
          ph  = (cyc - 1) / W;
          pos = (cyc - 1) % W;
          chk("sram_addr", 32'(sram_addr), 32'(exp_word*2 + ph));
          chk1("dq_oe", sram_dq_oe, exp_wr);
          chk1("we_n", sram_we_n, !(exp_wr && (W == 1 || pos < W-1)));
          if (exp_wr)
            chk("dq_out", 32'(sram_dq_out),
                (ph == 0) ? 32'(exp_data[15:0]) : 32'(exp_data[31:16]));
        end else begin
          chk1("we_n_quiet", sram_we_n, 1'b1);
          chk1("dq_oe_quiet", sram_dq_oe, 1'b0);
          if (exp_lat == 0) chk("sram_addr_hold", 32'(sram_addr), 32'(addr_before));
        end
        if (exp_ready) done_id = req_id;
        cyc++;
      end else begin
        chk1("idle_ready", bus.ready, 1'b1);
        chk1("idle_err", bus.err, 1'b0);
        chk1("idle_we_n", sram_we_n, 1'b1);
      end
    end
  end

  task automatic finish_up();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  inr;
    int  word;
    bit  byp_hit;
    logic [31:0] off;
    off  = a - BASE;
    inr  = (a >= BASE) && ((off >> 2) < (32'd1 << (AW-1)));
    word = int'(off >> 2);
`ifdef SRAM_LAST_READ_BYPASS_EN
    byp_hit = !w && inr && byp_valid && (byp_word == word);
`else
    byp_hit = 1'b0;
`endif
    exp_wr      = w;
    exp_err     = !inr;
    exp_word    = word;
    exp_data    = d;
    addr_before = sram_addr;
    exp_lat     = !inr ? 1 : (byp_hit ? 0 : 2*W + 1);
    if (w)        exp_rd = last_rd;
    else if (inr) exp_rd = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
    else          exp_rd = 32'h0;

    bus.rd_en   = r;
    bus.wr_en   = w;
    bus.address = a;
    bus.wr_data = d;
    req_id++;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (done_id != req_id && n < 40);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    if (done_id != req_id) begin
      tests_failed++;
      $display("FAIL timeout: access to %h never raised ready, expected within %0d cycles", a, exp_lat);
      finish_up();
    end
    chk("we_low_cycles", we_low_cnt, (w && inr) ? 2*((W == 1) ? 1 : W-1) : 0);

    if (inr) begin
      if (w) begin
        ref_mem[word] = d;
        if (byp_word == word) byp_valid = 1'b0;
      end else begin
        last_rd = exp_rd;
        if (!byp_hit) begin
          byp_valid = 1'b1;
          byp_word  = word;
        end
      end
    end else if (!w) begin
      last_rd = 32'h0;
    end
  endtask

  initial begin
    ref_mem[1]  = 32'hABCD1234;
    rst_n       = 1'b0;
    bus.rd_en   = 1'b1;
    bus.wr_en   = 1'b0;
    bus.address = 32'd1024;
    bus.wr_data = 32'h0;

    // Reset held with a pending read: everything parked, ready low.
    repeat (3) begin
      @(negedge clk);
      chk1("rst_ready", bus.ready, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk("rst_rd_data", bus.rd_data, 32'h0);
      chk("rst_sram_addr", 32'(sram_addr), 32'h0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
      chk1("rst_dq_oe", sram_dq_oe, 1'b0);
      chk1("rst_we_n", sram_we_n, 1'b1);
    end
    @(posedge clk);
    #1 bus.rd_en = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("lit_pad_lo", 32'(sram_arr[0]), 32'h0000BEEF);
    chk("lit_pad_hi", 32'(sram_arr[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("lit_rd_1024", bus.rd_data, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("lit_rd_1024_again", bus.rd_data, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("lit_rd_1028", bus.rd_data, 32'hABCD1234);
    access(1'b1, 1'b1, 32'd1032, 32'd5);
    chk("lit_rdwr_keeps_rd", bus.rd_data, 32'hABCD1234);
    access(1'b0, 1'b1, 32'd1032, 32'h0);
    chk("lit_rd_1032", bus.rd_data, 32'd5);
    access(1'b0, 1'b1, 32'd1020, 32'h0);
    chk("lit_rd_below_base", bus.rd_data, 32'h0);
    access(1'b0, 1'b1, 32'd1032, 32'h0);
    chk("lit_rd_1032_after_err", bus.rd_data, 32'd5);
    access(1'b1, 1'b0, 32'd1024, 32'h11223344);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("lit_rd_1024_new", bus.rd_data, 32'h11223344);
    access(1'b1, 1'b0, 32'd525308, 32'hCAFEF00D);
    chk("lit_pad_top_lo", 32'(sram_arr[18'h3FFFE]), 32'h0000F00D);
    chk("lit_pad_top_hi", 32'(sram_arr[18'h3FFFF]), 32'h0000CAFE);
    access(1'b0, 1'b1, 32'd525308, 32'h0);
    chk("lit_rd_top", bus.rd_data, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd525312, 32'h55555555);
    chk("lit_oor_write_keeps_rd", bus.rd_data, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    finish_up();
  end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Data-memory responder on the far side of the pipeline's MEM-stage interface (MEMread/MEMwrite/address/data → MEMresult).
- Replaces the single-cycle memory with an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two half-word SRAM phases, each lasting WAIT_CYCLES clocks.
- Drives a `ready` back-pressure signal. The core ORs `!ready` into its freeze/hazard path so MEM-stage inputs stay stable until `ready`.

Parameters:
- BASE_ADDR, 1024: first byte address mapped to SRAM; lower addresses are out of range.
- ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: clocks per half-word phase (≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- rd_en  in  1  read request (held until ready)
- wr_en  in  1  write request (held until ready)
- address  in  32  byte address, word aligned
- wr_data  in  32  store value
- rd_data  out  32  load result, valid when ready=1 after a read
- ready  out  1  1 = idle or access completing this cycle
- err  out  1  one-cycle pulse: out-of-range access completed
- sram_addr  out  ADDR_W  half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  read data from pad
- sram_we_n  out  1  SRAM write strobe, active-low

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rd_data=0; err=0; sram_addr=0; sram_dq_out=0; sram_dq_oe=0; sram_we_n=1; wait counter=0.
  - Reset mid-access aborts immediately; no partial-write guarantee.
- Request: req = rd_en | wr_en. wr_en has priority when both are high; the access is then a write.
- `ready` is combinational: (state==IDLE && !req) || state==DONE || state==ERR.
- Address mapping:
  - off = address − BASE_ADDR (32-bit subtract); word = off[31:2].
  - Out of range when address < BASE_ADDR or word ≥ 2^(ADDR_W−1).
  - Low half: sram_addr = {word, 1'b0}, carries bits [15:0]. High half: sram_addr = {word, 1'b1}, carries bits [31:16].
- FSM transitions:
  - IDLE → ERR on req with out-of-range address.
  - IDLE → LOW on req otherwise; counter cleared.
  - LOW → HIGH after WAIT_CYCLES clocks.
  - HIGH → DONE after WAIT_CYCLES clocks.
  - DONE → IDLE after 1 clock.
  - ERR → IDLE after 1 clock.
- ERR state:
  - ready=1, err=1 for that cycle.
  - Read returns rd_data=0. Write is dropped; no SRAM strobe.
- LOW/HIGH, write access:
  - sram_dq_oe=1, sram_dq_out = selected half, sram_we_n=0 for the first WAIT_CYCLES−1 clocks of the phase.
  - sram_we_n=1 on the last clock of the phase (address/data hold); when WAIT_CYCLES=1, we_n=0 for the single clock.
- LOW/HIGH, read access:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is sampled on the last clock of the phase into rd_data[15:0] (LOW) or rd_data[31:16] (HIGH).
- Latency: request seen at cycle 0; ready=1 at cycle 2·WAIT_CYCLES+1; the core advances on that edge.
- rd_data is held until the next completed read. Writes never modify rd_data.
- Back-to-back: a new request in the cycle after DONE starts at IDLE; a request is never accepted in the DONE cycle.
- Requests dropping mid-access (protocol violation) are ignored; the access completes.

Optional Feature:
- Macro: SRAM_LAST_READ_BYPASS_EN.
- With the macro, a one-entry buffer holds {valid, word, data} of the last completed read:
  - A read in IDLE whose word matches with valid=1 completes the same cycle: ready=1, rd_data driven from the buffer, no SRAM cycle.
  - Any write to the same word invalidates the buffer at DONE; reset clears valid.
- Without the macro: every read takes 2·WAIT_CYCLES+1 cycles and the buffer logic is absent.

Decomposition:
- Package arm_mem_pkg:
  - state enum {IDLE, LOW, HIGH, DONE, ERR}
  - BASE_ADDR default
  - half-select constants LO_HALF=0, HI_HALF=1
- Sub-module sram_wait_counter: loadable down-counter with a last-cycle flag, parameterised by WAIT_CYCLES.

Test Plan:
- Reset with rd_en=1: all outputs at reset values, ready=0 (req pending), state stays IDLE while rst=0.
- Write 0xDEADBEEF to 1024 then read 1024:
  - Write: sram_addr 0 (data 0xBEEF), then 1 (data 0xDEAD); we_n low for 1 clock per phase.
  - Read: rd_data=0xDEADBEEF; ready rises on cycle 5 for each access.
- Read 1028 with SRAM model returning 0x1234 (addr 2) and 0xABCD (addr 3) → rd_data=0xABCD1234.
- rd_en=wr_en=1 at 1032, wr_data=5 → write performed, rd_data unchanged; a following read of 1032 → 5.
- Read 1020 (below base) → ready and err on cycle 1, rd_data=0, no sram_we_n activity.
- With SRAM_LAST_READ_BYPASS_EN:
  - Repeated read of 1024 → ready=1 in cycle 0, no sram_addr change.
  - Write 1024, then read 1024 → full 5-cycle access.
